// File: rtl/adc_sample_averager_pkg.sv
// Shared ADC definitions: default sample width, averager state encoding and the
// mean-shift helper used to turn an N-sample sum into a truncated mean.
package adc_sample_averager_pkg;

  localparam int ADC_DW = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  // Dividing by N = 2^LOG2_N is a plain right shift by LOG2_N.
  function automatic int mean_shift(input int log2_n);
    return log2_n;
  endfunction

endpackage

// File: rtl/adc_sample_averager_avg_out_reg.sv
// Valid/ready output holding register for averaged results. A published mean
// loads only when the slot is free or draining this cycle; otherwise it is dropped.
module avg_out_reg #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          load_i,
  input  logic [DW-1:0] mean_i,
  input  logic          ready_i,
  input  logic          clr_ovr_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          ovr_o
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          xfer, accept, drop;

  assign xfer   = valid_q & ready_i;
  assign accept = load_i & (~valid_q | xfer);
  assign drop   = load_i & ~accept;

  always_comb begin
    data_d  = accept ? mean_i : data_q;
    valid_d = accept ? 1'b1 : (xfer ? 1'b0 : valid_q);
    // A drop in the same cycle as a clear must still be reported.
    ovr_d   = drop ? 1'b1 : (clr_ovr_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/adc_sample_averager.sv
// Accumulates 2^LOG2_N triggered ADC samples and publishes their truncated mean
// through a valid/ready port; aborts to IDLE whenever en or PLL lock drops.
module adc_sample_averager
  import adc_sample_averager_pkg::*;
#(
  parameter int DW     = ADC_DW,
  parameter int LOG2_N = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          locked,
  input  logic          en,
  input  logic          trig,
  input  logic [DW-1:0] adc_data,
  output logic [DW-1:0] avg_data,
  output logic          avg_valid,
  input  logic          avg_ready,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic          busy
);

  localparam int AW         = DW + LOG2_N;
  localparam int MEAN_SHIFT = mean_shift(LOG2_N);

  state_e            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic              run, last, pub_load;
  logic [AW-1:0]     sample_ext;
  logic [DW-1:0]     mean;

  assign run        = en & locked;
  assign last       = (cnt_q == {LOG2_N{1'b1}});
  assign sample_ext = {{LOG2_N{1'b0}}, adc_data};
  assign mean       = acc_q[AW-1:MEAN_SHIFT];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus accumulator/counter update; abort outranks trig and publish.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (run) state_d = ACCUM;
      end
      ACCUM: begin
        if (!run) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (trig) begin
          acc_d = acc_q + sample_ext;
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        if (!run) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          // A trig here is the first sample of the following block.
          state_d = ACCUM;
          acc_d   = trig ? sample_ext : '0;
          cnt_d   = trig ? LOG2_N'(1) : '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pub_load = (state_q == PUBLISH) && run;
    busy     = (state_q != IDLE);
  end

  avg_out_reg #(.DW(DW)) u_out (
    .clk       (clk),
    .nrst      (nrst),
    .load_i    (pub_load),
    .mean_i    (mean),
    .ready_i   (avg_ready),
    .clr_ovr_i (clr_ovr),
    .data_o    (avg_data),
    .valid_o   (avg_valid),
    .ovr_o     (overrun)
  );

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager at LOG2_N=2: per-cycle vector table
// plus hand sequences for abort/relock and asynchronous reset.
module tb_adc_sample_averager;

  localparam int DW     = 12;
  localparam int LOG2_N = 2;

  logic          clk = 1'b0;
  logic          nrst;
  logic          locked, en, trig, avg_ready, clr_ovr;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] avg_data;
  logic          avg_valid, overrun, busy;

  int errors = 0;
  int checks = 0;

  adc_sample_averager #(.DW(DW), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .locked    (locked),
    .en        (en),
    .trig      (trig),
    .adc_data  (adc_data),
    .avg_data  (avg_data),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, locked, trig;
    int         data;
    logic       ready, clr;
    logic       ev;
    int         ed;
    logic       eo, eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic l, input logic t, input int d,
                              input logic r, input logic c, input logic ev, input int ed,
                              input logic eo, input logic eb);
    vec_t v;
    v.en = e; v.locked = l; v.trig = t; v.data = d; v.ready = r; v.clr = c;
    v.ev = ev; v.ed = ed; v.eo = eo; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, then sample outputs 1 time unit later.
  task automatic apply(input vec_t v, input int idx);
    en = v.en; locked = v.locked; trig = v.trig; adc_data = DW'(v.data);
    avg_ready = v.ready; clr_ovr = v.clr;
    @(posedge clk);
    #1;
    chk("avg_valid", idx, int'(avg_valid), int'(v.ev));
    chk("avg_data",  idx, int'(avg_data),  v.ed);
    chk("overrun",   idx, int'(overrun),   int'(v.eo));
    chk("busy",      idx, int'(busy),      int'(v.eb));
  endtask

  task automatic rep(input int n, input logic t, input int d, input logic r,
                     input logic ev, input int ed, input logic eo);
    for (int i = 0; i < n; i++) tbl.push_back(mk(1, 1, t, d, r, 0, ev, ed, eo, 1));
  endtask

  initial begin
    nrst = 1'b0; locked = 0; en = 0; trig = 0; adc_data = '0; avg_ready = 0; clr_ovr = 0;

    // Basic average: trig in the IDLE cycle where en rises is ignored; 10,20,30,41 -> 25.
    tbl.push_back(mk(1, 1, 1, 99, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 10, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 20, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 30, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 41, 0, 0, 0, 0, 0, 1));   // now in PUBLISH
    tbl.push_back(mk(1, 1, 0, 0,  0, 0, 1, 25, 0, 1));  // 2nd edge after last trig
    tbl.push_back(mk(1, 1, 0, 0,  1, 0, 0, 25, 0, 1));  // transfer
    // Eight back-to-back trigs of 100 across PUBLISH with ready held high.
    rep(4, 1, 100, 1, 0, 25, 0);
    rep(1, 1, 100, 1, 1, 100, 0);
    rep(3, 1, 100, 1, 0, 100, 0);
    rep(1, 0, 0,   1, 1, 100, 0);
    rep(1, 0, 0,   1, 0, 100, 0);
    // Transfer and load in the same PUBLISH cycle.
    rep(4, 1, 8,  0, 0, 100, 0);
    rep(1, 0, 0,  0, 1, 8, 0);
    rep(4, 1, 12, 0, 1, 8, 0);
    rep(1, 0, 0,  1, 1, 12, 0);
    rep(1, 0, 0,  1, 0, 12, 0);
    // Overrun: means 5 then 9 with ready low; 9 is dropped.
    rep(4, 1, 5, 0, 0, 12, 0);
    rep(1, 0, 0, 0, 1, 5, 0);
    rep(4, 1, 9, 0, 1, 5, 0);
    rep(1, 0, 0, 0, 1, 5, 1);
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 5, 0, 1));   // clr_ovr
    rep(1, 0, 0, 1, 0, 5, 0);
    // Drop coinciding with clr_ovr: set wins.
    rep(4, 1, 3, 0, 0, 5, 0);
    rep(1, 0, 0, 0, 1, 3, 0);
    rep(4, 1, 6, 0, 1, 3, 0);
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 3, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 3, 0, 1));
    rep(1, 0, 0, 1, 0, 3, 0);

    #2;
    chk("rst_valid", -1, int'(avg_valid), 0);
    chk("rst_data",  -1, int'(avg_data),  0);
    chk("rst_ovr",   -1, int'(overrun),   0);
    chk("rst_busy",  -1, int'(busy),      0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Abort after 3 of 4 samples, then relock: partial sum must not carry over.
    for (int i = 0; i < 3; i++) apply(mk(1, 1, 1, 50, 0, 0, 0, 3, 0, 1), 100 + i);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 3, 0, 0), 103);
    apply(mk(1, 1, 1, 50, 0, 0, 0, 3, 0, 1), 104);
    for (int i = 0; i < 4; i++) apply(mk(1, 1, 1, 7, 0, 0, 0, 3, 0, 1), 105 + i);
    apply(mk(1, 1, 0, 0, 0, 0, 1, 7, 0, 1), 109);

    // Asynchronous reset between edges while a result is pending.
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_valid", 200, int'(avg_valid), 0);
    chk("arst_data",  200, int'(avg_data),  0);
    chk("arst_ovr",   200, int'(overrun),   0);
    chk("arst_busy",  200, int'(busy),      0);
    @(negedge clk);
    nrst = 1'b1;
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1), 201);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
